// File: rtl/alu_ctrl_pipe_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pipe_if
// Bundles the upstream handshake, the downstream hold/flush controls and the
// registered control outputs of the ID/EX ALU control stage.
//   master : pipeline side (drives opcode/alu_on/in_valid/stall/flush)
//   slave  : alu_ctrl_pipe (drives in_ready and all registered controls)
// Optional: ALU_ILLEGAL_TRAP_EN adds illegal_sticky and illegal_opc.
// ---------------------------------------------------------------------------
interface alu_ctrl_pipe_if #(
  parameter int OPC_W  = 11,
  parameter int ALU_CW = 3
);
  logic [OPC_W-1:0]  opcode;
  logic              alu_on;
  logic              in_valid;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [ALU_CW-1:0] alu_cntrl;
  logic [1:0]        unit_sel;
  logic              set_flags;
  logic              shift_left;
  logic              illegal;
  logic              mul_busy;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic              illegal_sticky;
  logic [10:0]       illegal_opc;
`endif

  modport master (
    output opcode, alu_on, in_valid, stall, flush,
    input  in_ready, out_valid, alu_cntrl, unit_sel, set_flags,
           shift_left, illegal, mul_busy
`ifdef ALU_ILLEGAL_TRAP_EN
    , input illegal_sticky, illegal_opc
`endif
  );

  modport slave (
    input  opcode, alu_on, in_valid, stall, flush,
    output in_ready, out_valid, alu_cntrl, unit_sel, set_flags,
           shift_left, illegal, mul_busy
`ifdef ALU_ILLEGAL_TRAP_EN
    , output illegal_sticky, illegal_opc
`endif
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pipe
// Registered ALU control stage at the ID/EX boundary. Decodes the 11-bit
// LEGv8 opcode (top 11 bits of opcode) into ALU op, execution unit select,
// flag-write and shift direction, with valid/ready handshake, stall, flush
// and a multi-cycle multiply wait.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : alu_ctrl_pipe_if.slave (handshake, stall/flush, controls)
// Optional macro ALU_ILLEGAL_TRAP_EN: records the first accepted illegal
//   opcode in illegal_sticky / illegal_opc (cleared only by reset).
// ---------------------------------------------------------------------------
module alu_ctrl_pipe #(
  parameter int OPC_W      = 11,
  parameter int ALU_CW     = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  alu_ctrl_pipe_if.slave  bus
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, VALID, MUL_WAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  mul_cnt;
  logic              out_valid_q;
  logic [2:0]        alu_q;
  logic [1:0]        unit_q;
  logic              flags_q;
  logic              shl_q;
  logic              ill_q;
  logic              busy_q;

  logic [10:0]       op11;
  logic [2:0]        dec_alu;
  logic [1:0]        dec_unit;
  logic              dec_flags;
  logic              dec_shl;
  logic              dec_ill;
  logic              dec_mul;
  logic              ready;
  logic              accept;
  logic              take_mul;

  assign op11 = bus.opcode[OPC_W-1 -: 11];

  // Opcode decode. With alu_on low every control stays zero and nothing is
  // flagged illegal; branches decode to pass-B on the ALU.
  always_comb begin
    dec_alu   = 3'b000;
    dec_unit  = 2'b00;
    dec_flags = 1'b0;
    dec_shl   = 1'b0;
    dec_ill   = 1'b0;
    dec_mul   = 1'b0;
    if (bus.alu_on) begin
      casez (op11)
        11'b10001011000: dec_alu = 3'b010;
        11'b10101011000: begin dec_alu = 3'b010; dec_flags = 1'b1; end
        11'b11001011000: dec_alu = 3'b011;
        11'b11101011000: begin dec_alu = 3'b011; dec_flags = 1'b1; end
        11'b1001000100?: dec_alu = 3'b010;
        11'b1101000100?: dec_alu = 3'b011;
        11'b11111000010,
        11'b11111000000: dec_alu = 3'b010;
        11'b10001010000: dec_alu = 3'b100;
        11'b10101010000: dec_alu = 3'b101;
        11'b11001010000: dec_alu = 3'b110;
        11'b11010011011: begin dec_unit = 2'b01; dec_shl = 1'b1; end
        11'b11010011010: dec_unit = 2'b01;
        11'b10011011000: begin dec_unit = 2'b10; dec_mul = 1'b1; end
        11'b100101?????,
        11'b10110100???,
        11'b01010100???: dec_alu = 3'b000;
        default:         dec_ill = 1'b1;
      endcase
    end
  end

  // The stage cannot take a new instruction while a multiply is in flight.
  assign ready    = !bus.stall && !bus.flush && (state != MUL_WAIT);
  assign accept   = bus.in_valid && ready;
  assign take_mul = dec_mul && (MUL_CYCLES > 1);

  // Main FSM and output register. Flush beats stall, stall freezes
  // everything, and the control fields only change on accept/flush/reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mul_cnt     <= '0;
      out_valid_q <= 1'b0;
      alu_q       <= 3'b000;
      unit_q      <= 2'b00;
      flags_q     <= 1'b0;
      shl_q       <= 1'b0;
      ill_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      mul_cnt     <= '0;
      out_valid_q <= 1'b0;
      alu_q       <= 3'b000;
      unit_q      <= 2'b00;
      flags_q     <= 1'b0;
      shl_q       <= 1'b0;
      ill_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (!bus.stall) begin
      case (state)
        MUL_WAIT: begin
          if (mul_cnt <= CNT_ONE) begin
            state       <= VALID;
            mul_cnt     <= '0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            mul_cnt <= mul_cnt - CNT_ONE;
          end
        end
        default: begin
          if (accept) begin
            alu_q   <= dec_alu;
            unit_q  <= dec_unit;
            flags_q <= dec_flags;
            shl_q   <= dec_shl;
            ill_q   <= dec_ill;
            if (take_mul) begin
              state       <= MUL_WAIT;
              mul_cnt     <= CNT_LOAD;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b1;
            end else begin
              state       <= VALID;
              out_valid_q <= 1'b1;
            end
          end else begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_cntrl  = ALU_CW'(alu_q);
  assign bus.unit_sel   = unit_q;
  assign bus.set_flags  = flags_q;
  assign bus.shift_left = shl_q;
  assign bus.illegal    = ill_q;
  assign bus.mul_busy   = busy_q;

`ifdef ALU_ILLEGAL_TRAP_EN
  logic        sticky_q;
  logic [10:0] opc_q;

  // Only the first accepted illegal opcode is kept; flush leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
      opc_q    <= '0;
    end else if (accept && dec_ill && !sticky_q) begin
      sticky_q <= 1'b1;
      opc_q    <= op11;
    end
  end

  assign bus.illegal_sticky = sticky_q;
  assign bus.illegal_opc    = opc_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_pipe
// Directed sequence followed by random traffic, each cycle compared against a
// table-driven reference model of the control stage.
// Optional macro ALU_ILLEGAL_TRAP_EN enables the sticky-trap checks.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_pipe;
  localparam int MUL_CYC = 4;
  localparam int NDEC    = 17;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  alu_ctrl_pipe_if #(.OPC_W(11), .ALU_CW(3)) bus ();

  alu_ctrl_pipe #(.OPC_W(11), .ALU_CW(3), .MUL_CYCLES(MUL_CYC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table: pattern string (MSB first, x = don't care) and
  // the resulting controls.
  string dec_pat [NDEC] = '{
    "10001011000", "10101011000", "11001011000", "11101011000",
    "1001000100x", "1101000100x", "11111000010", "11111000000",
    "10001010000", "10101010000", "11001010000", "11010011011",
    "11010011010", "10011011000", "100101xxxxx", "10110100xxx",
    "01010100xxx"};
  int dec_alu  [NDEC] = '{2, 2, 3, 3, 2, 3, 2, 2, 4, 5, 6, 0, 0, 0, 0, 0, 0};
  int dec_unit [NDEC] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0};
  int dec_flg  [NDEC] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int dec_shl  [NDEC] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  // Reference state, expressed as plain counts rather than FSM states.
  int          m_valid, m_alu, m_unit, m_flags, m_shl, m_ill, m_rem;
  int          m_sticky;
  logic [10:0] m_opc;

  function automatic bit pat_match(input string pat, input logic [10:0] op);
    for (int i = 0; i < 11; i++) begin
      byte c = pat[i];
      if (c != "x" && ((c == "1") != (op[10-i] == 1'b1))) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_decode(input logic [10:0] op, input logic on,
                              output int alu, output int unit, output int fl,
                              output int shl, output int ill, output int mul);
    int idx = -1;
    alu = 0; unit = 0; fl = 0; shl = 0; ill = 0; mul = 0;
    if (on) begin
      for (int i = 0; i < NDEC; i++)
        if (idx < 0 && pat_match(dec_pat[i], op)) idx = i;
      if (idx < 0) ill = 1;
      else begin
        alu = dec_alu[idx]; unit = dec_unit[idx];
        fl = dec_flg[idx];  shl = dec_shl[idx];
        mul = (unit == 2) ? 1 : 0;
      end
    end
  endtask

  function automatic logic [10:0] rand_op();
    logic [10:0] op;
    if ($urandom_range(0, 3) == 0) begin
      op = 11'($urandom);
    end else begin
      int k = $urandom_range(0, NDEC - 1);
      for (int i = 0; i < 11; i++) begin
        byte c = dec_pat[k][i];
        op[10-i] = (c == "x") ? 1'($urandom) : (c == "1");
      end
    end
    return op;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_alu = 0; m_unit = 0; m_flags = 0; m_shl = 0;
    m_ill = 0; m_rem = 0; m_sticky = 0; m_opc = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(m_valid));
    chk({tag, ".alu_cntrl"},  32'(bus.alu_cntrl),  32'(m_alu));
    chk({tag, ".unit_sel"},   32'(bus.unit_sel),   32'(m_unit));
    chk({tag, ".set_flags"},  32'(bus.set_flags),  32'(m_flags));
    chk({tag, ".shift_left"}, 32'(bus.shift_left), 32'(m_shl));
    chk({tag, ".illegal"},    32'(bus.illegal),    32'(m_ill));
    chk({tag, ".mul_busy"},   32'(bus.mul_busy),   32'(m_rem > 0));
`ifdef ALU_ILLEGAL_TRAP_EN
    chk({tag, ".sticky"},     32'(bus.illegal_sticky), 32'(m_sticky));
    chk({tag, ".ill_opc"},    32'(bus.illegal_opc),    32'(m_opc));
`endif
  endtask

  // One clock: drive inputs, check in_ready, clock, advance model, check.
  task automatic applyStimulus(input string tag, input logic [10:0] op,
                               input logic on, input logic vld,
                               input logic stl, input logic fl);
    int rdy, acc, a, u, f, s, il, mu;
    bus.opcode = op; bus.alu_on = on; bus.in_valid = vld;
    bus.stall = stl; bus.flush = fl;
    #1;
    rdy = (!stl && !fl && m_rem == 0) ? 1 : 0;
    acc = (vld && rdy != 0) ? 1 : 0;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
    model_decode(op, on, a, u, f, s, il, mu);
    @(posedge clk);
    if (fl) begin
      m_valid = 0; m_rem = 0; m_alu = 0; m_unit = 0;
      m_flags = 0; m_shl = 0; m_ill = 0;
    end else if (stl) begin
      m_valid = m_valid;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_valid = 1;
    end else if (acc != 0) begin
      m_alu = a; m_unit = u; m_flags = f; m_shl = s; m_ill = il;
      if (mu != 0 && MUL_CYC > 1) begin m_rem = MUL_CYC - 1; m_valid = 0; end
      else m_valid = 1;
      if (il != 0 && m_sticky == 0) begin m_sticky = 1; m_opc = op; end
    end else begin
      m_valid = 0;
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt, guard;
    checks = 0; errors = 0;
    model_reset();
    reset_n = 1'b0;
    bus.opcode = '0; bus.alu_on = 1'b0; bus.in_valid = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    reset_n = 1'b1;

    applyStimulus("adds", 11'b10101011000, 1, 1, 0, 0);
    chk("adds.alu_const", 32'(bus.alu_cntrl), 32'h2);
    chk("adds.flags_const", 32'(bus.set_flags), 32'h1);

    applyStimulus("b2b_subs", 11'b11101011000, 1, 1, 0, 0);
    chk("subs.alu_const", 32'(bus.alu_cntrl), 32'h3);
    applyStimulus("b2b_eor", 11'b11001010000, 1, 1, 0, 0);
    chk("eor.alu_const", 32'(bus.alu_cntrl), 32'h6);
    applyStimulus("b2b_lsl", 11'b11010011011, 1, 1, 0, 0);
    chk("lsl.unit_const", 32'(bus.unit_sel), 32'h1);
    applyStimulus("idle1", 11'd0, 0, 0, 0, 0);

    // Multiply with a two-cycle stall inside the wait.
    applyStimulus("mul_acc", 11'b10011011000, 1, 1, 0, 0);
    busy_cnt = bus.mul_busy ? 1 : 0;
    guard = 0;
    while (bus.mul_busy && guard < 20) begin
      applyStimulus("mul_wait", 11'd0, 0, 0, (guard == 1 || guard == 2), 0);
      if (bus.mul_busy) busy_cnt++;
      guard++;
    end
    chk("mul.busy_cycles", 32'(busy_cnt), 32'd5);
    chk("mul.out_valid_const", 32'(bus.out_valid), 32'h1);
    chk("mul.unit_const", 32'(bus.unit_sel), 32'h2);

    applyStimulus("aluoff_ldur", 11'b11111000010, 0, 1, 0, 0);
    chk("aluoff.illegal_const", 32'(bus.illegal), 32'h0);
    applyStimulus("illegal_ones", 11'b11111111111, 1, 1, 0, 0);
    chk("illegal.flag_const", 32'(bus.illegal), 32'h1);

    applyStimulus("add_for_flush", 11'b10001011000, 1, 1, 0, 0);
    applyStimulus("flush_valid", 11'b10001011000, 1, 1, 0, 1);
    chk("flush.out_valid_const", 32'(bus.out_valid), 32'h0);
    applyStimulus("after_flush", 11'd0, 0, 0, 0, 0);
    applyStimulus("mul_for_flush", 11'b10011011000, 1, 1, 0, 0);
    applyStimulus("mul_flush_w", 11'd0, 0, 0, 0, 0);
    applyStimulus("flush_mul", 11'd0, 0, 0, 0, 1);
    chk("flushmul.busy_const", 32'(bus.mul_busy), 32'h0);
    applyStimulus("after_flush2", 11'd0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus("mul_for_rst", 11'b10011011000, 1, 1, 0, 0);
    applyStimulus("mul_rst_w", 11'd0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async_rst");
    chk("async_rst.in_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus("adds_post_rst", 11'b10101011000, 1, 1, 0, 0);
    chk("adds2.alu_const", 32'(bus.alu_cntrl), 32'h2);

    applyStimulus("trap_first", 11'b00000000001, 1, 1, 0, 0);
    applyStimulus("trap_second", 11'b11111111111, 1, 1, 0, 0);
    applyStimulus("trap_flush", 11'd0, 0, 0, 0, 1);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("trap.sticky_const", 32'(bus.illegal_sticky), 32'h1);
    chk("trap.opc_const", 32'(bus.illegal_opc), 32'h001);
`endif

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", rand_op(), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
